// File: rtl/mc_ctrl_pkg.sv
// Shared types for the multicycle RV32I control unit: FSM states, opcodes,
// immediate formats, ALU operations and datapath mux select encodings.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR1    = 4'd11,
    S_JALR2    = 4'd12,
    S_LUI      = 4'd13,
    S_AUIPC    = 4'd14,
    S_ILLEGAL  = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100
  } imm_src_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    RES_ALUOUT = 2'b00,
    RES_RDATA  = 2'b01,
    RES_ALURES = 2'b10
  } result_src_t;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RS1   = 2'b10,
    SRCA_ZERO  = 2'b11
  } src_a_t;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } src_b_t;

  // Unrecognised opcodes fall back to the I format (encoding 000).
  function automatic imm_src_t imm_src_of(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_ITYPE, OP_JALR: return IMM_I;
      OP_STORE:                   return IMM_S;
      OP_BRANCH:                  return IMM_B;
      OP_LUI, OP_AUIPC:           return IMM_U;
      OP_JAL:                     return IMM_J;
      default:                    return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_fsm_alu_decoder.sv
// ALU decoder: maps the FSM's coarse ALU request plus funct fields onto the
// ALU operation code. Purely combinational.
module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  alu_op_t    alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       op5_i,
  input  logic       funct7b5_i,
  output alu_ctrl_t  alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      default: begin
        // funct7b5 only distinguishes sub from add; shifts are always logical.
        case (funct3_i)
          3'b000:         alu_control_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b001:         alu_control_o = ALU_SLL;
          3'b010, 3'b011: alu_control_o = ALU_SLT;
          3'b100:         alu_control_o = ALU_XOR;
          3'b101:         alu_control_o = ALU_SRL;
          3'b110:         alu_control_o = ALU_OR;
          default:        alu_control_o = ALU_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I control FSM with memory ready handshake and optional timeout.
// Build option ILLEGAL_TRAP_EN: an unsupported opcode parks the FSM in ILLEGAL until reset.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic [2:0] alu_control,
  output logic       illegal_instr,
  output logic       mem_timeout
);

  state_t      state_q, state_d;
  logic        illegal_q;
  logic        tmo_flag;

  logic        mem_req_c, mem_write_c, adr_src_c;
  logic        ir_write_c, pc_write_c, reg_write_c;
  result_src_t result_c;
  src_a_t      src_a_c;
  src_b_t      src_b_c;
  alu_op_t     alu_op_c;
  alu_ctrl_t   alu_ctrl_c;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_ILLEGAL) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req_c   = 1'b0;
    mem_write_c = 1'b0;
    adr_src_c   = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    reg_write_c = 1'b0;
    result_c    = RES_ALUOUT;
    src_a_c     = SRCA_PC;
    src_b_c     = SRCB_RS2;
    alu_op_c    = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        src_b_c   = SRCB_FOUR;
        result_c  = RES_ALURES;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is formed here so BRANCH can load it from ALUOut.
        src_a_c = SRCA_OLDPC;
        src_b_c = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR1;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        src_a_c = SRCA_RS1;
        src_b_c = SRCB_IMM;
        state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req_c = 1'b1;
        adr_src_c = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_c    = RES_RDATA;
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        adr_src_c   = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        src_a_c  = SRCA_RS1;
        alu_op_c = ALUOP_FUNCT;
        state_d  = S_ALUWB;
      end
      S_EXECI: begin
        src_a_c  = SRCA_RS1;
        src_b_c  = SRCB_IMM;
        alu_op_c = ALUOP_FUNCT;
        state_d  = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        src_a_c    = SRCA_RS1;
        alu_op_c   = ALUOP_SUB;
        pc_write_c = zero ^ funct3[0];
        state_d    = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target from ALUOut while the ALU forms the link address.
        src_a_c    = SRCA_OLDPC;
        src_b_c    = SRCB_FOUR;
        pc_write_c = 1'b1;
        state_d    = S_ALUWB;
      end
      S_JALR1: begin
        src_a_c = SRCA_RS1;
        src_b_c = SRCB_IMM;
        state_d = S_JALR2;
      end
      S_JALR2: begin
        src_a_c    = SRCA_OLDPC;
        src_b_c    = SRCB_FOUR;
        pc_write_c = 1'b1;
        state_d    = S_ALUWB;
      end
      S_LUI: begin
        src_a_c = SRCA_ZERO;
        src_b_c = SRCB_IMM;
        state_d = S_ALUWB;
      end
      S_AUIPC: begin
        src_a_c = SRCA_OLDPC;
        src_b_c = SRCB_IMM;
        state_d = S_ALUWB;
      end
      S_ILLEGAL: begin
`ifdef ILLEGAL_TRAP_EN
        state_d = S_ILLEGAL;
`else
        state_d = S_FETCH;
`endif
      end
      default: state_d = S_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op_c),
    .funct3_i      (funct3),
    .op5_i         (op[5]),
    .funct7b5_i    (funct7b5),
    .alu_control_o (alu_ctrl_c)
  );

  // Counts unanswered request cycles; saturates once the limit has flagged.
  if (MEM_TIMEOUT > 0) begin : g_tmo
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(MEM_TIMEOUT - 1);
    logic [CNT_W-1:0] cnt_q;
    logic             tmo_q;

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        cnt_q <= '0;
        tmo_q <= 1'b0;
      end else if (mem_ready) begin
        cnt_q <= '0;
      end else if (mem_req_c) begin
        if (cnt_q == LIMIT_M1) tmo_q <= 1'b1;
        else                   cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    assign tmo_flag = tmo_q;
  end else begin : g_no_tmo
    assign tmo_flag = 1'b0;
  end

  // Reset overrides every output combinationally, including the sticky flags.
  assign mem_req       = reset_n & mem_req_c;
  assign mem_write     = reset_n & mem_write_c;
  assign adr_src       = reset_n & adr_src_c;
  assign ir_write      = reset_n & ir_write_c;
  assign pc_write      = reset_n & pc_write_c;
  assign reg_write     = reset_n & reg_write_c;
  assign result_src    = reset_n ? result_c : 2'b00;
  assign alu_src_a     = reset_n ? src_a_c : 2'b00;
  assign alu_src_b     = reset_n ? src_b_c : 2'b00;
  assign imm_src       = reset_n ? imm_src_of(op) : 3'b000;
  assign alu_control   = reset_n ? alu_ctrl_c : 3'b000;
  assign illegal_instr = reset_n & illegal_q;
  assign mem_timeout   = reset_n & tmo_flag;

endmodule
